// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU flag bit positions and the writeback buffer entry.
package cpu_pkg;

   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_ZERO     = 1;
   localparam int FLAG_NEGATIVE = 2;
   localparam int FLAG_OVERFLOW = 3;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wr_en;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback handshake bundle: input side (ALU result) and output side (regfile write).
interface alu_wb_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [7:0]  in_flags;
   logic        in_flags_we;
   logic [4:0]  in_rd;
   logic        in_wr_en;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_wr_en;

   modport master (
      output in_valid, in_result, in_flags, in_flags_we, in_rd, in_wr_en, flush, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_wr_en
   );

   modport slave (
      input  in_valid, in_result, in_flags, in_flags_we, in_rd, in_wr_en, flush, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_wr_en
   );
endinterface

// File: rtl/wb_fifo.sv
// Valid/ready FIFO of DEPTH entries with synchronous flush.
// With ALU_WB_FWD_EN defined, storage and pointers are exported for the bypass mux.
module wb_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = AW + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [W-1:0]              out_data
`ifdef ALU_WB_FWD_EN
   ,
   output logic [DEPTH-1:0][W-1:0]   peek_mem,
   output logic [AW-1:0]             peek_rd_ptr,
   output logic [CW-1:0]             peek_count
`endif
);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    push, pop;

   assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // A pop in the flush cycle still happens on the bus; only state is cleared.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef ALU_WB_FWD_EN
   assign peek_mem    = mem_q;
   assign peek_rd_ptr = rd_ptr_q;
   assign peek_count  = count_q;
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: result buffer, architectural flags register and retire counter.
// Define ALU_WB_FWD_EN to add the fwd_* operand bypass from the youngest writing entry.
module alu_wb_stage
   import cpu_pkg::*;
#(
   parameter int         DEPTH     = 2,
   parameter logic [7:0] FLAGS_RST = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   alu_wb_stage_if.slave     bus,
   output logic [7:0]        flags_q,
   output logic [31:0]       retire_cnt
`ifdef ALU_WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [31:0]       fwd_data
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   wb_entry_t   in_ent, out_ent;
   logic        accept, retire;
   logic [7:0]  flags_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   assign in_ent = '{result: bus.in_result, rd: bus.in_rd, wr_en: bus.in_wr_en};

`ifdef ALU_WB_FWD_EN
   logic [DEPTH-1:0][ENTRY_W-1:0] fifo_mem;
   logic [AW-1:0]                 fifo_rd_ptr;
   logic [CW-1:0]                 fifo_count;
`endif

   wb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .in_valid   (bus.in_valid),
      .in_ready   (bus.in_ready),
      .in_data    (in_ent),
      .out_valid  (bus.out_valid),
      .out_ready  (bus.out_ready),
      .out_data   (out_ent)
`ifdef ALU_WB_FWD_EN
      ,
      .peek_mem   (fifo_mem),
      .peek_rd_ptr(fifo_rd_ptr),
      .peek_count (fifo_count)
`endif
   );

   assign bus.out_result = out_ent.result;
   assign bus.out_rd     = out_ent.rd;
   assign bus.out_wr_en  = out_ent.wr_en;

   // in_ready already folds in flush, so a flushed entry never commits its flags.
   assign accept = bus.in_valid && bus.in_ready;
   assign retire = bus.out_valid && bus.out_ready;

   always_comb begin
      flags_d      = flags_q;
      retire_cnt_d = retire_cnt_q + 32'(retire);
      if (accept && bus.in_flags_we) flags_d = bus.in_flags;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q      <= FLAGS_RST;
         retire_cnt_q <= '0;
      end else begin
         flags_q      <= flags_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;

`ifdef ALU_WB_FWD_EN
   logic [AW-1:0] fwd_idx;
   wb_entry_t     fwd_ent;

   // Walk oldest to youngest so the last match is the youngest writer.
   always_comb begin
      fwd_valid = 1'b0;
      fwd_rd    = '0;
      fwd_data  = '0;
      fwd_idx   = '0;
      fwd_ent   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = fifo_rd_ptr + AW'(i);
         fwd_ent = fifo_mem[fwd_idx];
         if ((CW'(i) < fifo_count) && fwd_ent.wr_en) begin
            fwd_valid = 1'b1;
            fwd_rd    = fwd_ent.rd;
            fwd_data  = fwd_ent.result;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: a queue model of the buffer, flags and retire counter.
module tb_alu_wb_stage;
   import cpu_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [7:0] FLAGS_RST = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  flags_q;
   logic [31:0] retire_cnt;
`ifdef ALU_WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   alu_wb_stage_if bus ();

   alu_wb_stage #(.DEPTH(DEPTH), .FLAGS_RST(FLAGS_RST)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .flags_q   (flags_q),
      .retire_cnt(retire_cnt)
`ifdef ALU_WB_FWD_EN
      ,
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   wb_entry_t   sb[$];
   logic [7:0]  exp_flags;
   logic [31:0] exp_ret;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put(input bit v, input logic [31:0] r, input logic [4:0] rd, input bit w,
                      input logic [7:0] f, input bit fwe);
      bus.in_valid    = v;
      bus.in_result   = r;
      bus.in_rd       = rd;
      bus.in_wr_en    = w;
      bus.in_flags    = f;
      bus.in_flags_we = fwe;
   endtask

   // One cycle: predict handshakes from the model, check pre-edge outputs, update model, step.
   task automatic tick();
      bit        acc, ret, mready;
      wb_entry_t e;
      #1;
      mready = (sb.size() < DEPTH) && !bus.flush;
      acc    = bus.in_valid && mready;
      ret    = (sb.size() != 0) && bus.out_ready;
      chk("in_ready", bus.in_ready, mready);
      chk("out_valid", bus.out_valid, sb.size() != 0);
      if (sb.size() != 0) chk("out_entry", {bus.out_result, bus.out_rd, bus.out_wr_en}, sb[0]);
`ifdef ALU_WB_FWD_EN
      begin
         bit          fv = 1'b0;
         logic [4:0]  frd = '0;
         logic [31:0] fd = '0;
         foreach (sb[i]) if (sb[i].wr_en) begin fv = 1'b1; frd = sb[i].rd; fd = sb[i].result; end
         chk("fwd_valid", fwd_valid, fv);
         if (fv) chk("fwd_rd_data", {fwd_rd, fwd_data}, {frd, fd});
      end
`endif
      if (ret) begin
         e = sb.pop_front();
         exp_ret++;
      end
      if (acc) begin
         sb.push_back('{result: bus.in_result, rd: bus.in_rd, wr_en: bus.in_wr_en});
         if (bus.in_flags_we) exp_flags = bus.in_flags;
      end
      if (bus.flush) sb.delete();
      @(posedge clk);
      #1;
      chk("flags_q", flags_q, exp_flags);
      chk("retire_cnt", retire_cnt, exp_ret);
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      put(0, '0, '0, 0, '0, 0);
      exp_flags = FLAGS_RST;
      exp_ret   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_flags", flags_q, FLAGS_RST);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_out_fields", {bus.out_result, bus.out_rd, bus.out_wr_en}, 38'd0);
      rst = 1'b0;

      // Single accept, visible the next cycle, then retired.
      bus.out_ready = 1'b1;
      put(1, 32'h0000_0005, 5'd3, 1, 8'h00, 0);
      tick();
      chk("r034_out", {bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en}, {1'b1, 32'd5, 5'd3, 1'b1});
      put(0, '0, '0, 0, '0, 0);
      tick();
      chk("r034_retire", retire_cnt, 32'd1);

      // Backpressure: third entry waits while full, then everything drains in order.
      bus.out_ready = 1'b0;
      put(1, 32'hA0, 5'd1, 1, 8'h00, 0); tick();
      put(1, 32'hA1, 5'd2, 0, 8'h00, 0); tick();
      chk("r035_full", bus.in_ready, 1'b0);
      put(1, 32'hA2, 5'd4, 1, 8'h00, 0); tick(); tick();
      bus.out_ready = 1'b1;
      tick(); tick();
      put(0, '0, '0, 0, '0, 0);
      tick(); tick();
      chk("r035_drained", retire_cnt, 32'd4);

      // Flags commit only with in_flags_we.
      put(1, 32'h10, 5'd5, 1, 8'h02, 1); tick();
      put(1, 32'h11, 5'd6, 1, 8'h05, 0); tick();
      put(0, '0, '0, 0, '0, 0); tick();
      chk("r036_flags", flags_q, 8'h02);

      // Flush with a full buffer, a same-cycle retire and a flag-writing incoming entry.
      bus.out_ready = 1'b0;
      put(1, 32'h20, 5'd7, 1, 8'h00, 0); tick();
      put(1, 32'h21, 5'd8, 1, 8'h00, 0); tick();
      put(1, 32'h22, 5'd9, 1, 8'h08, 1);
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.flush = 1'b0;
      put(0, '0, '0, 0, '0, 0);
      chk("r037_empty", bus.out_valid, 1'b0);
      chk("r037_flags", flags_q, 8'h02);
      tick();

      // Random mixed stream, including wr_en=0 entries.
      for (int k = 0; k < 80; k++) begin
         put(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
             8'($urandom), 1'($urandom_range(0, 1)));
         bus.out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      put(0, '0, '0, 0, '0, 0);
      bus.out_ready = 1'b1;
      repeat (3) tick();

      // Retire counter wrap.
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      exp_ret = 32'hFFFF_FFFF;
      put(1, 32'h30, 5'd10, 1, 8'h00, 0); tick();
      put(0, '0, '0, 0, '0, 0); tick();
      chk("r038_wrap", retire_cnt, 32'd0);

      // Asynchronous reset with entries in flight.
      bus.out_ready = 1'b0;
      put(1, 32'h40, 5'd11, 1, 8'h01, 1); tick();
      put(1, 32'h41, 5'd12, 1, 8'h00, 0); tick();
      put(0, '0, '0, 0, '0, 0);
      rst = 1'b1;
      #1;
      chk("r029_flushed", {bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en}, 39'd0);
      chk("r029_flags", flags_q, FLAGS_RST);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_flags = FLAGS_RST;
      exp_ret   = '0;
      chk("r029_ready", bus.in_ready, 1'b1);
      tick();

`ifdef ALU_WB_FWD_EN
      put(1, 32'h50, 5'd4, 1, 8'h00, 0); tick();
      put(1, 32'h51, 5'd7, 1, 8'h00, 0); tick();
      put(0, '0, '0, 0, '0, 0);
      chk("r039_young", {fwd_valid, fwd_rd}, {1'b1, 5'd7});
      bus.flush = 1'b1; tick(); bus.flush = 1'b0;
      chk("r039_none", fwd_valid, 1'b0);
      put(1, 32'h60, 5'd4, 1, 8'h00, 0); tick();
      put(1, 32'h61, 5'd7, 0, 8'h00, 0); tick();
      put(0, '0, '0, 0, '0, 0);
      chk("r039_skip", {fwd_valid, fwd_rd, fwd_data}, {1'b1, 5'd4, 32'h60});
      bus.out_ready = 1'b1;
      repeat (3) tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
